// File: rtl/spi_reg_pkg.sv
// Shared types and sizing helpers for the SPI register bank.
// Optional build macro used by the bank: SPI_REG_READBACK_EN.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2,
        REJECT = 2'd3
    } state_t;

    // Total bits in one address+data frame.
    function automatic int frame_len(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

    // The bit counter has to hold FRAME+1 so an overlong frame stays distinguishable.
    function automatic int cnt_width(input int addr_w, input int data_w);
        return $clog2(frame_len(addr_w, data_w) + 2);
    endfunction

endpackage

// File: rtl/spi_reg_bank_sync.sv
// Two-flop synchroniser for one asynchronous pin. With EDGE_DET set, a third
// flop provides single-cycle rise/fall pulses of the synchronised level.
module spi_in_sync #(
    parameter bit EDGE_DET = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;

    // Metastability filter: pin -> s1 -> s2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign q = s2;

    generate
        if (EDGE_DET) begin : g_edge
            logic s3;

            // Delayed copy of the synced level for edge detection.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) s3 <= 1'b0;
                else     s3 <= s2;
            end

            assign rise = s2 & ~s3;
            assign fall = ~s2 & s3;
        end else begin : g_no_edge
            assign rise = 1'b0;
            assign fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave register bank, receiver running entirely in the clk domain.
// Frames (address then data, MSB first) are committed only when chip select
// releases after exactly FRAME bits; anything else raises frame_err.
// Build macro SPI_REG_READBACK_EN adds a MISO read path of the pre-write value.
//
// state  | meaning
// IDLE   | waiting for a synced cs_n falling edge while armed
// SHIFT  | cs_n low, shifting mosi on synced sclk rising edges
// COMMIT | one cycle after a good frame was written (wr_stb high)
// REJECT | one cycle after a bad frame was dropped (frame_err high)
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 2,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sclk,
    input  logic                           cs_n,
    input  logic                           mosi,
    output logic                           miso,
    output logic [(2**ADDR_W)*DATA_W-1:0]  regs,
    output logic                           wr_stb,
    output logic [ADDR_W-1:0]              wr_addr,
    output logic                           frame_err
);

    localparam int NREG  = 2**ADDR_W;
    localparam int FRAME = frame_len(ADDR_W, DATA_W);
    localparam int CW    = cnt_width(ADDR_W, DATA_W);

    localparam logic [CW-1:0] CNT_FRAME   = CW'(FRAME);
    localparam logic [CW-1:0] CNT_MAX     = CW'(FRAME + 1);
    localparam logic [CW-1:0] CNT_ADDR    = CW'(ADDR_W);
    localparam logic [CW-1:0] CNT_ADDR_M1 = CW'(ADDR_W - 1);

    logic sclk_lvl_unused;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_q;
    logic cs_rise;
    logic cs_fall;
    logic mosi_q;
    logic mosi_rise_unused;
    logic mosi_fall_unused;

    spi_in_sync #(.EDGE_DET(1'b1)) u_sync_sclk (
        .clk  (clk),
        .rst  (rst),
        .d    (sclk),
        .q    (sclk_lvl_unused),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_in_sync #(.EDGE_DET(1'b1)) u_sync_cs (
        .clk  (clk),
        .rst  (rst),
        .d    (cs_n),
        .q    (cs_q),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_in_sync #(.EDGE_DET(1'b0)) u_sync_mosi (
        .clk  (clk),
        .rst  (rst),
        .d    (mosi),
        .q    (mosi_q),
        .rise (mosi_rise_unused),
        .fall (mosi_fall_unused)
    );

    state_t              state;
    state_t              state_nxt;
    logic                armed;
    logic [CW-1:0]       cnt;
    logic [FRAME-1:0]    shreg;
    logic [DATA_W-1:0]   mem [NREG];
    logic                start_frame;
    logic                do_shift;
    logic                do_commit;
    logic                do_reject;
    logic [ADDR_W-1:0]   frame_addr;
    logic [DATA_W-1:0]   frame_data;

    assign frame_addr = shreg[FRAME-1 -: ADDR_W];
    assign frame_data = shreg[DATA_W-1:0];

    // Arm only after cs_n has been seen high, so a frame in flight at reset release is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       armed <= 1'b0;
        else if (cs_q) armed <= 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and frame actions; cs_n release takes priority over a coincident sclk edge.
    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        do_shift    = 1'b0;
        do_commit   = 1'b0;
        do_reject   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cs_fall && armed) begin
                    start_frame = 1'b1;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    if (cnt == CNT_FRAME) begin
                        do_commit = 1'b1;
                        state_nxt = COMMIT;
                    end else begin
                        do_reject = 1'b1;
                        state_nxt = REJECT;
                    end
                end else if (sclk_rise) begin
                    do_shift = 1'b1;
                end
            end
            COMMIT:  state_nxt = IDLE;
            REJECT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bit counter (saturating one past FRAME) and receive shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (start_frame) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (do_shift) begin
            shreg <= {shreg[FRAME-2:0], mosi_q};
            if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
        end
    end

    // Register array and last-written address, updated only on a clean commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) mem[k] <= RESET_VAL;
            wr_addr <= '0;
        end else if (do_commit) begin
            mem[frame_addr] <= frame_data;
            wr_addr         <= frame_addr;
        end
    end

    // Single-cycle result strobes, aligned with the updated register contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_stb    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            wr_stb    <= do_commit;
            frame_err <= do_reject;
        end
    end

    generate
        for (genvar k = 0; k < NREG; k++) begin : g_flat
            assign regs[k*DATA_W +: DATA_W] = mem[k];
        end
    endgenerate

`ifdef SPI_REG_READBACK_EN
    logic [DATA_W-1:0] rd_sh;
    logic              rd_load;

    // Flag the cycle after the last address bit lands; shreg low bits then hold the address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_load <= 1'b0;
        else     rd_load <= do_shift && (cnt == CNT_ADDR_M1);
    end

    // Read shifter: load pre-write value, then advance on falls after the first data bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_sh <= '0;
        end else if (start_frame) begin
            rd_sh <= '0;
        end else if (rd_load) begin
            rd_sh <= mem[shreg[ADDR_W-1:0]];
        end else if (state == SHIFT && sclk_fall && !cs_rise && cnt > CNT_ADDR) begin
            rd_sh <= {rd_sh[DATA_W-2:0], 1'b0};
        end
    end

    assign miso = (state == SHIFT && cnt >= CNT_ADDR && !rd_load) ? rd_sh[DATA_W-1] : 1'b0;
`else
    logic unused_sclk_fall;

    assign unused_sclk_fall = sclk_fall;
    assign miso             = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank (DATA_W=8, ADDR_W=2, RESET_VAL=8'h5A).
module tb_spi_reg_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [31:0] regs;
    logic        wr_stb;
    logic [1:0]  wr_addr;
    logic        frame_err;

    spi_reg_bank #(
        .DATA_W    (8),
        .ADDR_W    (2),
        .RESET_VAL (8'h5A)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .regs      (regs),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    int          stb_cnt = 0;
    int          err_cnt = 0;
    logic        both_seen = 1'b0;
    logic [31:0] regs_at_stb = '0;
    logic [1:0]  addr_at_stb = '0;

    // Pulse monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_stb) begin
                stb_cnt     = stb_cnt + 1;
                regs_at_stb = regs;
                addr_at_stb = wr_addr;
            end
            if (frame_err) err_cnt = err_cnt + 1;
            if (wr_stb && frame_err) both_seen = 1'b1;
        end
    end

    typedef struct {
        int          nbits;
        logic [15:0] bits;
        int          exp_stb;
        int          exp_err;
        logic [31:0] exp_regs;
        logic [1:0]  exp_addr;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift_bit(input logic b, inout logic [15:0] mbits);
        mosi = b;
        wait_clk(5);
        mbits = {mbits[14:0], miso};
        sclk = 1'b1;
        wait_clk(5);
        sclk = 1'b0;
    endtask

    task automatic run_frame(input int nbits, input logic [15:0] bits, output logic [15:0] mbits);
        logic [15:0] m;
        m = '0;
        cs_n = 1'b0;
        wait_clk(6);
        for (int i = nbits - 1; i >= 0; i--) shift_bit(bits[i], m);
        wait_clk(6);
        cs_n = 1'b1;
        wait_clk(12);
        mbits = m;
    endtask

    initial begin
        int          s0;
        int          e0;
        logic [15:0] mb;

        vecs[0] = '{10, 16'h02C3, 1, 0, 32'h5AC35A5A, 2'd2};
        vecs[1] = '{ 7, 16'h0055, 0, 1, 32'h5AC35A5A, 2'd0};
        vecs[2] = '{ 0, 16'h0000, 0, 1, 32'h5AC35A5A, 2'd0};
        vecs[3] = '{11, 16'h07FF, 0, 1, 32'h5AC35A5A, 2'd0};
        vecs[4] = '{10, 16'h0101, 1, 0, 32'h5AC3015A, 2'd1};
        vecs[5] = '{10, 16'h00FF, 1, 0, 32'h5AC301FF, 2'd0};
        vecs[6] = '{10, 16'h0300, 1, 0, 32'h00C301FF, 2'd3};
        vecs[7] = '{ 9, 16'h01FF, 0, 1, 32'h00C301FF, 2'd0};

        wait_clk(5);
        rst = 1'b0;
        wait_clk(6);
        check("reset_regs", regs, 32'h5A5A5A5A);
        check("reset_wr_stb", {31'd0, wr_stb}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_miso", {31'd0, miso}, 32'd0);
        check("reset_wr_addr", {30'd0, wr_addr}, 32'd0);

        for (int v = 0; v < 8; v++) begin
            s0 = stb_cnt;
            e0 = err_cnt;
            run_frame(vecs[v].nbits, vecs[v].bits, mb);
            check($sformatf("vec%0d_stb_cycles", v), 32'(stb_cnt - s0), 32'(vecs[v].exp_stb));
            check($sformatf("vec%0d_err_cycles", v), 32'(err_cnt - e0), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d_regs", v), regs, vecs[v].exp_regs);
            if (vecs[v].exp_stb != 0) begin
                check($sformatf("vec%0d_wr_addr", v), {30'd0, addr_at_stb}, {30'd0, vecs[v].exp_addr});
                check($sformatf("vec%0d_regs_at_stb", v), regs_at_stb, vecs[v].exp_regs);
            end
        end

        // Reset in the middle of a frame; the tail of that frame must be ignored.
        mb = '0;
        cs_n = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 4; i++) shift_bit(1'b1, mb);
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        s0 = stb_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 6; i++) shift_bit(i[0], mb);
        wait_clk(6);
        cs_n = 1'b1;
        wait_clk(12);
        check("midrst_stb_cycles", 32'(stb_cnt - s0), 32'd0);
        check("midrst_err_cycles", 32'(err_cnt - e0), 32'd0);
        check("midrst_regs", regs, 32'h5A5A5A5A);

        s0 = stb_cnt;
        run_frame(10, 16'h0277, mb);
        check("post_rst_stb_cycles", 32'(stb_cnt - s0), 32'd1);
        check("post_rst_regs", regs, 32'h5A775A5A);
        check("post_rst_wr_addr", {30'd0, wr_addr}, 32'd2);

`ifdef SPI_REG_READBACK_EN
        run_frame(10, 16'h03A5, mb);
        check("rb_setup_regs", regs, 32'hA5775A5A);
        run_frame(10, 16'h030F, mb);
        check("rb_miso_bits", {22'd0, mb[9:0]}, 32'h000000A5);
        check("rb_regs_after", regs, 32'h0F775A5A);
        check("rb_miso_idle", {31'd0, miso}, 32'd0);
`endif

        check("stb_err_overlap", {31'd0, both_seen}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

Parametrised SPI slave register bank that replaces the raw SCLK-clocked shift register with a system-clock-domain receiver. SCLK, CS_N and MOSI are synchronised into `clk`. Address+data frames are decoded and committed into an array of holding registers only on a clean chip-select release; partial or overlong frames are rejected. Sits between the board SPI pins and the control/LED logic in `top`, which consumes the flattened register outputs and the write strobe.

## Interface
Parameters:
- `DATA_W`, 8, data bits per register (≥2)
- `ADDR_W`, 2, address bits; register count NREG = 2**ADDR_W (≥1)
- `RESET_VAL`, 0, reset value of every register (DATA_W bits)

Ports:
- `clk`  in  1  system clock; all logic on posedge
- `rst`  in  1  reset, asynchronous, active-high
- `sclk`  in  1  SPI clock pin, mode 0, asynchronous to clk
- `cs_n`  in  1  SPI chip select pin, active-low, asynchronous
- `mosi`  in  1  SPI data in, asynchronous
- `miso`  out  1  SPI data out (see Configuration)
- `regs`  out  NREG*DATA_W  flattened registers; reg k at [k*DATA_W +: DATA_W]
- `wr_stb`  out  1  one-cycle pulse when a register is committed
- `wr_addr`  out  ADDR_W  address of the last commit
- `frame_err`  out  1  one-cycle pulse when a frame is rejected

## Operation
- Each of sclk, cs_n and mosi passes through a 2-flop synchroniser; sclk and cs_n get a third flop for edge detection.
- Frame length is FRAME = ADDR_W + DATA_W bits, MSB first: address, then data.
- Frame start: synced cs_n falling edge with `armed`=1. This clears the bit counter and shift register.
- While cs_n is low, each synced sclk rising edge shifts synced mosi into the LSB of the FRAME-bit shift register. The bit counter increments and saturates at FRAME+1.
- Frame end: synced cs_n rising edge.
  - Count == FRAME: regs[addr] <= data. `wr_addr` <= addr. `wr_stb`=1 for one cycle.
  - Any other count, including 0: no write; `frame_err`=1 for one cycle.
- A cs_n rising edge in the same clk as an sclk rising edge: the end-of-frame action wins and the sclk edge is discarded.
- States: IDLE (cs_n high) -> SHIFT (cs_n low, armed) -> COMMIT/REJECT (one cycle) -> IDLE.
- `armed` is cleared by reset and set once synced cs_n is seen high. A frame already in progress when reset releases is ignored entirely: no write, no error.
- Reset values: regs = RESET_VAL; wr_stb, frame_err, wr_addr, miso, counter and shift register = 0; state IDLE.

## Timing
- Pin-to-internal latency: 2 clk for synchronisation, plus 1 clk for edge detection.
- cs_n rising at the pin -> wr_stb/frame_err asserted 3–4 clk later.
- `regs` shows the new value in the same cycle wr_stb is high (registered).
- clk must be ≥8× sclk. The SCLK high and low phases must each be ≥3 clk.
- There must be ≥4 clk between the last sclk edge and cs_n rising.
- wr_stb and frame_err are never high in the same cycle. Back-to-back frames need ≥4 clk of cs_n high.

## Configuration
- `SPI_REG_READBACK_EN` defined:
  - When the counter reaches ADDR_W, a DATA_W read shift register loads regs[addr] (the pre-write value).
  - `miso` presents the read-register MSB and advances on each synced sclk falling edge during the data phase.
  - `miso` = 0 during the address phase and when cs_n is high.
- Not defined: `miso` is tied to 0 and no read shift register is built.

## Structure
- Package `spi_reg_pkg` holds:
  - FRAME-length and counter-width functions: counter width = $clog2(FRAME+2).
  - The state enum (IDLE, SHIFT, COMMIT, REJECT).
- Sub-module `spi_in_sync`: 2-flop synchroniser with optional rise/fall detect outputs. Instantiated three times.

## Test plan
- **Reset:** DATA_W=8, ADDR_W=2, RESET_VAL=8'h5A, rst pulse -> all four regs = 8'h5A; wr_stb=0; frame_err=0; miso=0.
- **Valid write:** frame addr=2'b10, data=8'hC3, sclk = clk/10 -> exactly one wr_stb; wr_addr=2; regs[2]=8'hC3; regs 0, 1, 3 unchanged.
- **Short frame:** 7 bits then cs_n high -> frame_err pulse; no wr_stb; regs unchanged. Same for 0 bits (cs_n low/high only) -> frame_err.
- **Long frame:** 11 bits -> frame_err; regs unchanged. A following valid frame addr=1, data=8'h01 -> regs[1]=8'h01.
- **Reset mid-frame:** assert rst after 4 bits, release while cs_n is still low, finish the frame -> no wr_stb and no frame_err. The next full frame commits normally.
- **Readback (SPI_REG_READBACK_EN):** regs[3]=8'hA5, then frame addr=3, data=8'h0F -> miso shifts out A5 MSB first during the data phase; regs[3]=8'h0F afterwards.
